// File: rtl/cmd_pkg.sv
// Shared types and constants for the SUMP/OLS host command front end.
package cmd_pkg;

    // Assembly FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARG  = 2'd1,
        EXEC = 2'd2
    } cmd_state_t;

    // Opcode bit that marks a 5-byte long command.
    localparam int LONG_CMD_BIT = 7;
    // Argument bytes that follow a long opcode, LSB first.
    localparam int ARG_BYTES    = 4;

    localparam logic [7:0] CMD_RESET    = 8'h00;
    localparam logic [7:0] CMD_RUN      = 8'h01;
    localparam logic [7:0] CMD_ID       = 8'h02;
    localparam logic [7:0] CMD_METADATA = 8'h04;
    localparam logic [7:0] CMD_FINISH   = 8'h05;
    localparam logic [7:0] CMD_FLAGS    = 8'h82;

endpackage

// File: rtl/cmd_receiver_if.sv
// Received byte stream from the FTDI FIFO / UART into the command receiver.
//
// Handshake: rx_data is meaningful only while rx_valid=1. A byte transfers on
// a rising clock edge where rx_valid && rx_ready. While rx_valid=1 and
// rx_ready=0 the source must hold rx_data and rx_valid unchanged.
interface cmd_receiver_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    // Byte source side.
    modport master (output rx_data, output rx_valid, input  rx_ready);
    // Command receiver side.
    modport slave  (input  rx_data, input  rx_valid, output rx_ready);
endinterface

// File: rtl/cmd_timer.sv
// Inter-byte timeout counter for partially received long commands.
// Counts idle clocks while enabled; expire flags the cycle in which the
// count reaches TIMEOUT-1 and no byte arrives. TIMEOUT=0 never expires.
module cmd_timer #(
    parameter int unsigned TIMEOUT       = 1000000,
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic clock,
    input  logic extReset_n,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int unsigned TERM_INT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [TIMEOUT_WIDTH-1:0] TERM = TIMEOUT_WIDTH'(TERM_INT);

    logic [TIMEOUT_WIDTH-1:0] count;

    generate
        if (TIMEOUT == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            assign expire = enable && !clear && (count == TERM);
        end
    endgenerate

    // Idle-clock counter: held at zero outside ARG and restarted by every byte.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            count <= '0;
        end else if (!enable || clear || expire) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cmd_receiver.sv
// SUMP/OLS command assembler: turns the host byte stream into opcode,
// config_data and a one-cycle execute pulse for the analyzer core.
// Short commands are one byte (bit7=0); long commands are an opcode with
// bit7=1 followed by four argument bytes, LSB first.
module cmd_receiver
    import cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT       = 1000000,
    parameter int unsigned TIMEOUT_WIDTH = 24
) (
    input  logic           clock,
    input  logic           extReset_n,
    cmd_receiver_if.slave  bus,
    output logic [7:0]     opcode,
    output logic [31:0]    config_data,
    output logic           execute,
    output logic           cmd_timeout,
    output logic           busy,
    output cmd_state_t     fsm_state
);

    cmd_state_t  state;
    cmd_state_t  state_next;
    logic [7:0]  hold_opcode;
    logic [31:0] shift;
    logic [1:0]  byte_count;
    logic        accept;
    logic        expire;
    logic        load_short;
    logic        load_long_op;
    logic        load_arg;
    logic        load_done;

    // The only cycle that refuses bytes is the single EXEC cycle.
    assign bus.rx_ready = (state != EXEC);
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign execute      = (state == EXEC);
    assign busy         = (state != IDLE);
    assign fsm_state    = state;

    cmd_timer #(
        .TIMEOUT       (TIMEOUT),
        .TIMEOUT_WIDTH (TIMEOUT_WIDTH)
    ) u_timer (
        .clock      (clock),
        .extReset_n (extReset_n),
        .enable     (state == ARG),
        .clear      (accept),
        .expire     (expire)
    );

    // State register.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and datapath load decisions.
    always_comb begin
        state_next   = state;
        load_short   = 1'b0;
        load_long_op = 1'b0;
        load_arg     = 1'b0;
        load_done    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.rx_data[LONG_CMD_BIT]) begin
                        load_long_op = 1'b1;
                        state_next   = ARG;
                    end else begin
                        load_short = 1'b1;
                        state_next = EXEC;
                    end
                end
            end
            ARG: begin
                if (accept) begin
                    load_arg = 1'b1;
                    if (byte_count == 2'(ARG_BYTES - 1)) begin
                        load_done  = 1'b1;
                        state_next = EXEC;
                    end
                end else if (expire) begin
                    state_next = IDLE;
                end
            end
            EXEC: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Argument assembly and registered command outputs.
    always_ff @(posedge clock or negedge extReset_n) begin
        if (!extReset_n) begin
            hold_opcode <= 8'h00;
            shift       <= 32'h0;
            byte_count  <= 2'd0;
            opcode      <= 8'h00;
            config_data <= 32'h0;
            cmd_timeout <= 1'b0;
        end else begin
            cmd_timeout <= expire;
            if (load_short) begin
                opcode      <= bus.rx_data;
                config_data <= 32'h0;
            end
            if (load_long_op) begin
                hold_opcode <= bus.rx_data;
                shift       <= 32'h0;
                byte_count  <= 2'd0;
            end
            if (load_arg) begin
                shift[{byte_count, 3'b000} +: 8] <= bus.rx_data;
                byte_count <= byte_count + 2'd1;
            end
            if (load_done) begin
                opcode      <= hold_opcode;
                config_data <= {bus.rx_data, shift[23:0]};
            end
            // A discarded partial command leaves opcode/config_data untouched.
            if (expire) begin
                shift      <= 32'h0;
                byte_count <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_cmd_receiver.sv
// Directed bench for cmd_receiver with a command-level reference model,
// an expected-command queue and hand-computed literal expectations.
module tb_cmd_receiver;
    import cmd_pkg::*;

    localparam int unsigned TMO = 16;

    logic        clk;
    logic        rst_n;
    logic [7:0]  opcode;
    logic [31:0] config_data;
    logic        execute;
    logic        cmd_timeout;
    logic        busy;
    cmd_state_t  fsm_state;

    cmd_receiver_if bus ();

    cmd_receiver #(
        .TIMEOUT       (TMO),
        .TIMEOUT_WIDTH (8)
    ) dut (
        .clock       (clk),
        .extReset_n  (rst_n),
        .bus         (bus.slave),
        .opcode      (opcode),
        .config_data (config_data),
        .execute     (execute),
        .cmd_timeout (cmd_timeout),
        .busy        (busy),
        .fsm_state   (fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exec_cnt = 0;
    int to_cnt   = 0;
    int exec_cyc[$];
    logic [39:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]  m_op;
    logic [31:0] m_cfg;
    logic        m_exec;
    logic        m_to;
    logic [7:0]  m_part[$];
    int          m_gap;

    // Compare on the falling edge, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        logic       acc;
        logic       n_exec;
        logic       n_to;
        if (!rst_n) begin
            m_op = 8'h00; m_cfg = 32'h0; m_exec = 1'b0; m_to = 1'b0;
            m_part.delete(); m_gap = 0;
        end
        check("execute",     {39'd0, execute},     {39'd0, m_exec});
        check("cmd_timeout", {39'd0, cmd_timeout}, {39'd0, m_to});
        check("rx_ready",    {39'd0, bus.rx_ready}, {39'd0, !m_exec});
        check("busy",        {39'd0, busy},        {39'd0, (m_exec || m_part.size() > 0)});
        check("opcode",      {32'd0, opcode},      {32'd0, m_op});
        check("config_data", {8'd0, config_data},  {8'd0, m_cfg});
        if (execute === 1'b1) begin
            exec_cnt++;
            exec_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("sb_unexpected_exec", {opcode, config_data}, 40'hFF_FFFF_FFFF);
            end else begin
                check("sb_command", {opcode, config_data}, exp_q.pop_front());
            end
        end
        if (cmd_timeout === 1'b1) to_cnt++;

        if (rst_n) begin
            acc    = bus.rx_valid && !m_exec;
            n_exec = 1'b0;
            n_to   = 1'b0;
            if (acc) begin
                m_gap = 0;
                if (m_part.size() == 0 && !bus.rx_data[7]) begin
                    m_op   = bus.rx_data;
                    m_cfg  = 32'h0;
                    n_exec = 1'b1;
                end else begin
                    m_part.push_back(bus.rx_data);
                    if (m_part.size() == 5) begin
                        m_op   = m_part[0];
                        m_cfg  = {m_part[4], m_part[3], m_part[2], m_part[1]};
                        n_exec = 1'b1;
                        m_part.delete();
                    end
                end
            end else if (m_part.size() > 0) begin
                m_gap++;
                if (TMO != 0 && m_gap == TMO) begin
                    n_to = 1'b1;
                    m_part.delete();
                    m_gap = 0;
                end
            end
            m_exec = n_exec;
            m_to   = n_to;
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic r;
        bit   done;
        done = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            r = bus.rx_ready;
            @(posedge clk);
            #1;
            if (r) done = 1;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL handshake: byte %0h not accepted within 20 cycles", b);
        end
        bus.rx_valid = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    int base;
    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_opcode",   {32'd0, opcode}, 40'h0);
        check("rst_config",   {8'd0, config_data}, 40'h0);
        check("rst_execute",  {39'd0, execute}, 40'h0);
        check("rst_rx_ready", {39'd0, bus.rx_ready}, 40'h1);
        check("rst_busy",     {39'd0, busy}, 40'h0);
        rst_n = 1'b1;
        idle(2);

        // Short command
        exp_q.push_back({8'h01, 32'h0});
        send_byte(8'h01);
        check("short_exec",   {39'd0, execute}, 40'h1);
        check("short_opcode", {32'd0, opcode}, 40'h01);
        check("short_ready",  {39'd0, bus.rx_ready}, 40'h0);
        idle(1);
        check("short_pulse_end", {39'd0, execute}, 40'h0);
        check("short_ready_back", {39'd0, bus.rx_ready}, 40'h1);
        idle(1);

        // Long command, back to back
        exp_q.push_back({8'hC0, 32'h44332211});
        send_byte(8'hC0);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        check("long_hold_opcode", {32'd0, opcode}, 40'h01);
        check("long_no_exec", {39'd0, execute}, 40'h0);
        send_byte(8'h44);
        check("long_exec",   {39'd0, execute}, 40'h1);
        check("long_opcode", {32'd0, opcode}, 40'hC0);
        check("long_config", {8'd0, config_data}, 40'h44332211);
        idle(2);

        // Gapped source, then a byte held through the EXEC cycle
        base = to_cnt;
        exp_q.push_back({8'h82, 32'h00000001});
        send_byte(8'h82);
        idle(10); send_byte(8'h01);
        idle(10); send_byte(8'h00);
        idle(10); send_byte(8'h00);
        idle(10); send_byte(8'h00);
        check("gap_config", {8'd0, config_data}, 40'h00000001);
        exp_q.push_back({8'h05, 32'h0});
        send_byte(8'h05);
        check("held_byte_exec", {32'd0, opcode}, 40'h05);
        check("gap_no_timeout", to_cnt - base, 0);
        idle(2);

        // Timeout discards a partial command
        base = to_cnt;
        send_byte(8'h80);
        send_byte(8'hAA);
        idle(16);
        idle(1);
        check("timeout_pulse", to_cnt - base, 1);
        check("timeout_opcode", {32'd0, opcode}, 40'h05);
        check("timeout_config", {8'd0, config_data}, 40'h0);
        exp_q.push_back({8'h02, 32'h0});
        send_byte(8'h02);
        check("after_timeout_opcode", {32'd0, opcode}, 40'h02);
        idle(2);

        // Byte on the terminal cycle wins
        base = to_cnt;
        exp_q.push_back({8'h80, 32'hDDCCBBAA});
        send_byte(8'h80);
        send_byte(8'hAA);
        idle(15);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        check("terminal_config", {8'd0, config_data}, 40'hDDCCBBAA);
        idle(20);
        check("terminal_no_timeout", to_cnt - base, 0);

        // Reset mid-command
        base = exec_cnt;
        send_byte(8'hC1);
        send_byte(8'h55);
        rst_n = 1'b0;
        #1;
        check("midrst_opcode", {32'd0, opcode}, 40'h0);
        check("midrst_config", {8'd0, config_data}, 40'h0);
        check("midrst_busy",   {39'd0, busy}, 40'h0);
        check("midrst_ready",  {39'd0, bus.rx_ready}, 40'h1);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        exp_q.push_back({8'hC1, 32'h04030201});
        send_byte(8'hC1);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        check("midrst_config_after", {8'd0, config_data}, 40'h04030201);
        idle(2);
        check("midrst_single_exec", exec_cnt - base, 1);

        // Resync burst of five reset bytes
        base = exec_cnt;
        for (int i = 0; i < 5; i++) exp_q.push_back({CMD_RESET, 32'h0});
        for (int i = 0; i < 5; i++) send_byte(CMD_RESET);
        idle(3);
        check("burst_exec_count", exec_cnt - base, 5);
        if (exec_cyc.size() >= 5) begin
            for (int i = exec_cyc.size() - 4; i < exec_cyc.size(); i++)
                check("burst_spacing", exec_cyc[i] - exec_cyc[i-1], 2);
        end
        check("sb_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog");
    end

endmodule
